slow_clock_monitor: RTL
=======================

Name: slow_clock_monitor

Overview:
Receive-side checker for the divided slow clock produced by the team's clock divider. Samples the slow clock (or any slow square wave) in the fast clk domain and measures its period and high time in clk cycles. Flags in-range, lock and loss-of-signal conditions for on-board self-test and bench checking of divider output.

Parameters:
CNT_W, 28, width of period/high-time counters and outputs
EXP_PERIOD, 10_000_002, expected period in clk cycles (divider toggling every 5_000_001 cycles)
TOL, 1000, allowed absolute deviation from EXP_PERIOD for in_range
TIMEOUT, 20_000_000, clk cycles without a rising edge before timeout; must be < 2**CNT_W
LOCK_N, 3, consecutive in-range measurements required to assert locked

Ports:
clk  input  1  fast system clock
reset  input  1  asynchronous, active-high reset
slow_in  input  1  slow clock under test, asynchronous to clk
period  output  CNT_W  last measured period in clk cycles
high_cycles  output  CNT_W  clk cycles slow level was 1 during last period
period_valid  output  1  one-cycle pulse when period/high_cycles/in_range update
in_range  output  1  |period - EXP_PERIOD| <= TOL for last measurement
locked  output  1  LOCK_N consecutive in-range measurements, no timeout since
timeout  output  1  no rising edge for TIMEOUT cycles; sticky until next period_valid

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All outputs and internal registers clear to 0 on reset; FSM to IDLE.
- Input path: 2-FF synchronizer (reset 0) -> level s; registered copy s_d. rise = s & ~s_d. slow_in rising edge to rise high: 2-3 clk cycles.
- Counters: cnt (cycles since last rise), hcnt (cycles with s=1 since last rise). Both saturate at 2**CNT_W-1, never wrap.
- FSM states IDLE, MEASURE, LOST.
- IDLE: on rise -> MEASURE, cnt<=1, hcnt<=1 (rise cycle counts, s=1). No period_valid on first edge.
- MEASURE, cycle without rise: cnt+1; hcnt+1 if s=1. If cnt reaches TIMEOUT -> LOST, timeout<=1, locked<=0, lock counter<=0.
- MEASURE, cycle with rise: period<=cnt, high_cycles<=hcnt, in_range computed from cnt, period_valid<=1 next cycle (outputs update together, one cycle after rise), timeout<=0, cnt<=1, hcnt<=1. Stay MEASURE.
- Period definition: number of clk cycles between consecutive detected rising edges (rise-to-rise distance).
- in_range: unsigned compare, no overflow: (cnt >= EXP_PERIOD-TOL) && (cnt <= EXP_PERIOD+TOL); lower bound clamps at 0 if TOL > EXP_PERIOD.
- Lock counter (width clog2(LOCK_N+1)): +1 on in-range measurement (saturate at LOCK_N), cleared on out-of-range or timeout. locked = (lock counter == LOCK_N), registered, same cycle as period_valid.
- LOST: counters held; on rise -> MEASURE as from IDLE (arm only, no period_valid); timeout stays 1 until first valid measurement after recovery.
- Rise and timeout on same cycle: rise wins (measurement taken, no timeout).
- Constant slow_in (0 or 1): enters LOST after TIMEOUT cycles; period/high_cycles retain last values.
- Reset mid-measurement: immediate clear, next rise only arms.

Optional Feature:
SLOW_CLK_FILTER_EN: when defined, a glitch filter (parameter FILT_N, default 4) sits between synchronizer and edge detector; the filtered level changes only after the synced level has been stable FILT_N consecutive cycles. Adds FILT_N cycles of latency to rise; pulses shorter than FILT_N cycles are ignored entirely. When undefined, s is the raw synchronizer output and single-cycle glitches produce edges.

Test Plan:
- EXP_PERIOD=4, TOL=0, LOCK_N=3, TIMEOUT=16; slow_in toggling every 2 clk -> after 1st rise no valid; each later period_valid shows period=4, high_cycles=2, in_range=1; locked=1 at 3rd valid pulse.
- Same, then one period stretched to 6 (high 3, low 3) -> period=6, in_range=0, locked=0; 3 further 4-cycle periods -> locked=1 again.
- Stop toggling (hold 0) -> timeout=1, locked=0 exactly 16 cycles after last rise; resume toggling -> timeout clears on 1st period_valid (2nd rise after resume).
- Duty check: high 1 cycle, low 5 cycles -> period=6, high_cycles=1.
- Assert reset mid-period -> all outputs 0 same cycle; next rise produces no period_valid.
- With SLOW_CLK_FILTER_EN, FILT_N=4: insert 1-cycle high glitch in low phase -> no extra period_valid, period unchanged; without macro -> spurious short period reported.

Source files
------------

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor: measures the period and high time of a slow square wave
// (typically the divided clock) in fast clk cycles and flags in-range, lock and
// loss-of-signal conditions.
// Optional build macro SLOW_CLK_FILTER_EN adds a glitch filter (parameter FILT_N)
// between the synchronizer and the rising-edge detector.
module slow_clock_monitor #(
   parameter int CNT_W      = 28,
   parameter int EXP_PERIOD = 10_000_002,
   parameter int TOL        = 1000,
   parameter int TIMEOUT    = 20_000_000,
   parameter int LOCK_N     = 3
`ifdef SLOW_CLK_FILTER_EN
   ,
   parameter int FILT_N     = 4
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             slow_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_cycles,
   output logic             period_valid,
   output logic             in_range,
   output logic             locked,
   output logic             timeout
);

   localparam int LOCK_W = $clog2(LOCK_N + 1);
   localparam int LO_BOUND_INT = (TOL > EXP_PERIOD) ? 0 : (EXP_PERIOD - TOL);
   localparam logic [CNT_W:0]   LO_BOUND    = (CNT_W + 1)'(LO_BOUND_INT);
   localparam logic [CNT_W:0]   HI_BOUND    = (CNT_W + 1)'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [LOCK_W-1:0] LOCK_MAX   = LOCK_W'(LOCK_N);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOST    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_stateNext;

   logic r_sync1;
   logic r_sync2;
   logic w_level;
   logic r_levelDly;
   logic w_rise;

   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_hcnt;
   logic [CNT_W-1:0]  w_cntInc;
   logic [CNT_W-1:0]  w_hcntInc;
   logic [LOCK_W-1:0] r_lockCnt;
   logic [LOCK_W-1:0] w_lockNext;
   logic              w_inRange;

   logic w_arm;
   logic w_count;
   logic w_take;
   logic w_lose;

   // Two-flop synchronizer bringing the asynchronous slow input into the clk domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= slow_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef SLOW_CLK_FILTER_EN
   localparam int FILT_W = $clog2(FILT_N + 1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_N - 1);

   logic              r_filt;
   logic [FILT_W-1:0] r_filtCnt;

   // Glitch filter: the filtered level follows the synced level only after it has differed for FILT_N cycles in a row
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_filt    <= 1'b0;
         r_filtCnt <= '0;
      end else if (r_sync2 == r_filt) begin
         r_filtCnt <= '0;
      end else if (r_filtCnt == FILT_LAST) begin
         r_filt    <= r_sync2;
         r_filtCnt <= '0;
      end else begin
         r_filtCnt <= r_filtCnt + 1'b1;
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync2;
`endif

   // Delayed copy of the level so a rising edge shows up as a one-cycle strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_levelDly <= 1'b0;
      end else begin
         r_levelDly <= w_level;
      end
   end

   assign w_rise    = w_level & ~r_levelDly;
   assign w_cntInc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
   assign w_hcntInc = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + 1'b1;
   assign w_inRange = ({1'b0, r_cnt} >= LO_BOUND) && ({1'b0, r_cnt} <= HI_BOUND);
   assign w_lockNext = !w_inRange ? '0 :
                       (r_lockCnt == LOCK_MAX) ? r_lockCnt : r_lockCnt + 1'b1;

   // State register for the measurement FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic; a rise always beats a timeout on the same cycle
   always_comb begin
      w_stateNext = r_state;
      w_arm       = 1'b0;
      w_count     = 1'b0;
      w_take      = 1'b0;
      w_lose      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_stateNext = MEASURE;
               w_arm       = 1'b1;
            end
         end
         MEASURE: begin
            if (w_rise) begin
               w_take = 1'b1;
            end else if (r_cnt >= TIMEOUT_CNT) begin
               w_stateNext = LOST;
               w_lose      = 1'b1;
            end else begin
               w_count = 1'b1;
            end
         end
         LOST: begin
            if (w_rise) begin
               w_stateNext = MEASURE;
               w_arm       = 1'b1;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Measurement datapath: counters, published results, lock tracking and the sticky timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_hcnt       <= '0;
         r_lockCnt    <= '0;
         period       <= '0;
         high_cycles  <= '0;
         period_valid <= 1'b0;
         in_range     <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (w_arm) begin
            r_cnt  <= CNT_ONE;
            r_hcnt <= CNT_ONE;
         end else if (w_count) begin
            r_cnt <= w_cntInc;
            if (w_level) begin
               r_hcnt <= w_hcntInc;
            end
         end else if (w_take) begin
            period       <= r_cnt;
            high_cycles  <= r_hcnt;
            in_range     <= w_inRange;
            period_valid <= 1'b1;
            timeout      <= 1'b0;
            r_lockCnt    <= w_lockNext;
            locked       <= (w_lockNext == LOCK_MAX);
            r_cnt        <= CNT_ONE;
            r_hcnt       <= CNT_ONE;
         end else if (w_lose) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            r_lockCnt <= '0;
         end
      end
   end

endmodule
